// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles and branch/jump flushes for IF/ID and ID/EX.
// Optional perf counters (stall_cnt, flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UseRs,
  input  logic       ID_UseRt,
  input  logic [4:0] EX_Rw,
  input  logic       EX_RegWr,
  input  logic       EX_MemtoReg,
  input  logic       EX_BrTaken,
  input  logic       EX_Jump,
  output logic       PC_Wr,
  output logic       IF_ID_Wr,
  output logic       IF_ID_flush,
  output logic       ID_EX_bubble,
  output logic       ID_EX_flush,
  output logic       stall_active
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [0:0] {RUN, LD_STALL} st_e;

  st_e              st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;
  logic             redirect;

  // A load in EX whose destination feeds an operand read in ID; r0 never creates a dependency.
  assign load_use = EX_MemtoReg & EX_RegWr & (EX_Rw != 5'd0) &
                    ((ID_UseRs & (ID_Rs == EX_Rw)) | (ID_UseRt & (ID_Rt == EX_Rw)));
  assign redirect = EX_BrTaken | EX_Jump;

  // State register, updated on the same edge as the pipeline registers.
  always_ff @(negedge Clk) begin
    if (Rst) begin
      st  <= RUN;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Next state: redirect squashes the dependent ID instruction, so it suppresses the stall.
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    case (st)
      RUN: begin
        if (!redirect && load_use && (LOAD_STALL_CYCLES > 1)) begin
          st_nxt  = LD_STALL;
          cnt_nxt = CNT_W'(LOAD_STALL_CYCLES - 1);
        end
      end
      LD_STALL: begin
        if (cnt == CNT_W'(1)) begin
          st_nxt  = RUN;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        st_nxt  = RUN;
        cnt_nxt = '0;
      end
    endcase
  end

  // Mealy outputs; reset holds the front end and squashes both pipeline registers.
  always_comb begin
    PC_Wr        = 1'b1;
    IF_ID_Wr     = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    ID_EX_flush  = 1'b0;
    stall_active = 1'b0;
    if (Rst) begin
      PC_Wr       = 1'b0;
      IF_ID_Wr    = 1'b0;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else begin
      case (st)
        RUN: begin
          if (redirect) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
          end else if (load_use) begin
            PC_Wr        = 1'b0;
            IF_ID_Wr     = 1'b0;
            ID_EX_bubble = 1'b1;
            stall_active = 1'b1;
          end
        end
        LD_STALL: begin
          PC_Wr        = 1'b0;
          IF_ID_Wr     = 1'b0;
          ID_EX_bubble = 1'b1;
          stall_active = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Event counters, wrapping modulo 2^32.
  always_ff @(negedge Clk) begin
    if (Rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(ID_EX_bubble);
      flush_cnt <= flush_cnt + 32'(ID_EX_flush);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with stall depths 1, 3 and 4 driven from shared stimulus.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] rw;
    logic       wr;
    logic       mtr;
    logic       br;
    logic       jp;
    logic       rst;
  } stim_t;

  // Expected vector order: {PC_Wr, IF_ID_Wr, IF_ID_flush, ID_EX_bubble, ID_EX_flush, stall_active}
  localparam logic [5:0] NORM  = 6'b110000;
  localparam logic [5:0] STALL = 6'b000101;
  localparam logic [5:0] REDIR = 6'b111010;
  localparam logic [5:0] RSTV  = 6'b001010;

  localparam stim_t IDLE    = '0;
  localparam stim_t HAZ_RS  = '{rs:5'd8, rt:5'd0, urs:1'b1, urt:1'b0, rw:5'd8, wr:1'b1,
                                mtr:1'b1, br:1'b0, jp:1'b0, rst:1'b0};

  logic       Clk = 1'b1;
  logic       Rst = 1'b1;
  logic [4:0] ID_Rs = '0, ID_Rt = '0, EX_Rw = '0;
  logic       ID_UseRs = 1'b0, ID_UseRt = 1'b0, EX_RegWr = 1'b0, EX_MemtoReg = 1'b0;
  logic       EX_BrTaken = 1'b0, EX_Jump = 1'b0;

  logic pc1, ifw1, iff1, bub1, exf1, sa1;
  logic pc3, ifw3, iff3, bub3, exf3, sa3;
  logic pc4, ifw4, iff4, bub4, exf4, sa4;
  logic [5:0] obs1, obs3, obs4;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] scnt1, fcnt1, scnt3, fcnt3, scnt4, fcnt4;
`endif

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  always #5 Clk = ~Clk;

  assign obs1 = {pc1, ifw1, iff1, bub1, exf1, sa1};
  assign obs3 = {pc3, ifw3, iff3, bub3, exf3, sa3};
  assign obs4 = {pc4, ifw4, iff4, bub4, exf4, sa4};

  hazard_ctrl #(.LOAD_STALL_CYCLES(1)) u1 (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .EX_Rw(EX_Rw), .EX_RegWr(EX_RegWr), .EX_MemtoReg(EX_MemtoReg), .EX_BrTaken(EX_BrTaken),
    .EX_Jump(EX_Jump), .PC_Wr(pc1), .IF_ID_Wr(ifw1), .IF_ID_flush(iff1), .ID_EX_bubble(bub1),
    .ID_EX_flush(exf1), .stall_active(sa1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(scnt1), .flush_cnt(fcnt1)
`endif
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3)) u3 (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .EX_Rw(EX_Rw), .EX_RegWr(EX_RegWr), .EX_MemtoReg(EX_MemtoReg), .EX_BrTaken(EX_BrTaken),
    .EX_Jump(EX_Jump), .PC_Wr(pc3), .IF_ID_Wr(ifw3), .IF_ID_flush(iff3), .ID_EX_bubble(bub3),
    .ID_EX_flush(exf3), .stall_active(sa3)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(scnt3), .flush_cnt(fcnt3)
`endif
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(4)) u4 (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .EX_Rw(EX_Rw), .EX_RegWr(EX_RegWr), .EX_MemtoReg(EX_MemtoReg), .EX_BrTaken(EX_BrTaken),
    .EX_Jump(EX_Jump), .PC_Wr(pc4), .IF_ID_Wr(ifw4), .IF_ID_flush(iff4), .ID_EX_bubble(bub4),
    .ID_EX_flush(exf4), .stall_active(sa4)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(scnt4), .flush_cnt(fcnt4)
`endif
  );

  // Protocol: no redirect while the front end is held; bubble and flush never coincide.
  always @(negedge Clk) begin
    if (!Rst) begin
      assert (!((sa1 | sa3 | sa4) && (EX_BrTaken | EX_Jump)))
        else $error("redirect asserted during a load stall");
      assert (!(bub1 && exf1) && !(bub3 && exf3) && !(bub4 && exf4))
        else $error("bubble and flush both asserted");
    end
  end

  task automatic drive(input stim_t s);
    ID_Rs = s.rs; ID_Rt = s.rt; ID_UseRs = s.urs; ID_UseRt = s.urt;
    EX_Rw = s.rw; EX_RegWr = s.wr; EX_MemtoReg = s.mtr;
    EX_BrTaken = s.br; EX_Jump = s.jp; Rst = s.rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      drive(IDLE);
    end
  endtask

  task automatic test_reset();
    stim_t s;
    logic [5:0] e;
    s = IDLE;
    s.rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk);
      drive(s);
      for (int k = 0; k < 3; k++) exp_q.push_back(RSTV);
      #1;
      e = exp_q.pop_front(); checks++;
      if (obs1 !== e) begin errors++; $display("FAIL reset_u1 cyc%0d: got %b expected %b", i, obs1, e); end
      e = exp_q.pop_front(); checks++;
      if (obs3 !== e) begin errors++; $display("FAIL reset_u3 cyc%0d: got %b expected %b", i, obs3, e); end
      e = exp_q.pop_front(); checks++;
      if (obs4 !== e) begin errors++; $display("FAIL reset_u4 cyc%0d: got %b expected %b", i, obs4, e); end
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (scnt3 !== 32'd0 || fcnt3 !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", scnt3, fcnt3);
    end
`endif
  endtask

  task automatic test_load_use_3();
    logic [5:0] e;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      drive(i == 0 ? HAZ_RS : IDLE);
      exp_q.push_back(i < 3 ? STALL : NORM);
      #1;
      e = exp_q.pop_front(); checks++;
      if (obs3 !== e) begin errors++; $display("FAIL load_use_3 cyc%0d: got %b expected %b", i, obs3, e); end
    end
    idle(5);
`ifdef HAZARD_PERF_CNT_EN
    #1;
    checks++;
    if (scnt3 !== 32'd3 || fcnt3 !== 32'd0) begin
      errors++; $display("FAIL perf_stall_3: got %0d/%0d expected 3/0", scnt3, fcnt3);
    end
`endif
  endtask

  task automatic test_load_use_1();
    logic [5:0] e;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk);
      drive(i == 0 ? HAZ_RS : IDLE);
      exp_q.push_back(i == 0 ? STALL : NORM);
      #1;
      e = exp_q.pop_front(); checks++;
      if (obs1 !== e) begin errors++; $display("FAIL load_use_1 cyc%0d: got %b expected %b", i, obs1, e); end
    end
    idle(5);
  endtask

  task automatic test_back_to_back();
    logic [5:0] e;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      drive(i < 2 ? HAZ_RS : IDLE);
      exp_q.push_back(i < 2 ? STALL : NORM);
      #1;
      e = exp_q.pop_front(); checks++;
      if (obs1 !== e) begin errors++; $display("FAIL back_to_back cyc%0d: got %b expected %b", i, obs1, e); end
    end
    idle(5);
  endtask

  task automatic test_redirect();
    stim_t s;
    logic [5:0] e;
    // Taken branch with an rt load-use hazard: flush wins, no stall follows (depth 3).
    s = '{rs:5'd0, rt:5'd8, urs:1'b0, urt:1'b1, rw:5'd8, wr:1'b1, mtr:1'b1, br:1'b1, jp:1'b0, rst:1'b0};
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk);
      drive(i == 0 ? s : IDLE);
      exp_q.push_back(i == 0 ? REDIR : NORM);
      #1;
      e = exp_q.pop_front(); checks++;
      if (obs3 !== e) begin errors++; $display("FAIL branch_vs_load cyc%0d: got %b expected %b", i, obs3, e); end
    end
    // Jump with an rs load-use hazard on depth 1.
    s = HAZ_RS;
    s.jp = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk);
      drive(i == 0 ? s : IDLE);
      exp_q.push_back(i == 0 ? REDIR : NORM);
      #1;
      e = exp_q.pop_front(); checks++;
      if (obs1 !== e) begin errors++; $display("FAIL jump_vs_load cyc%0d: got %b expected %b", i, obs1, e); end
    end
    idle(5);
  endtask

  task automatic test_no_hazard();
    stim_t s [4];
    logic [5:0] e;
    s[0] = '{rs:5'd0, rt:5'd0, urs:1'b1, urt:1'b1, rw:5'd0, wr:1'b1, mtr:1'b1, br:1'b0, jp:1'b0, rst:1'b0};
    s[1] = '{rs:5'd0, rt:5'd9, urs:1'b1, urt:1'b0, rw:5'd9, wr:1'b1, mtr:1'b1, br:1'b0, jp:1'b0, rst:1'b0};
    s[2] = '{rs:5'd8, rt:5'd0, urs:1'b1, urt:1'b0, rw:5'd8, wr:1'b1, mtr:1'b0, br:1'b0, jp:1'b0, rst:1'b0};
    s[3] = '{rs:5'd8, rt:5'd0, urs:1'b1, urt:1'b0, rw:5'd8, wr:1'b0, mtr:1'b1, br:1'b0, jp:1'b0, rst:1'b0};
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      drive(s[i]);
      exp_q.push_back(NORM);
      #1;
      e = exp_q.pop_front(); checks++;
      if (obs4 !== e) begin errors++; $display("FAIL no_hazard case%0d: got %b expected %b", i, obs4, e); end
    end
    idle(2);
  endtask

  task automatic test_rs_eq_rt();
    stim_t s;
    logic [5:0] e;
    s = '{rs:5'd8, rt:5'd8, urs:1'b1, urt:1'b1, rw:5'd8, wr:1'b1, mtr:1'b1, br:1'b0, jp:1'b0, rst:1'b0};
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      drive(i == 0 ? s : IDLE);
      exp_q.push_back(i < 3 ? STALL : NORM);
      #1;
      e = exp_q.pop_front(); checks++;
      if (obs3 !== e) begin errors++; $display("FAIL rs_eq_rt cyc%0d: got %b expected %b", i, obs3, e); end
    end
    idle(5);
  endtask

  task automatic test_reset_mid_stall();
    stim_t s [4];
    logic [5:0] ev [4];
    logic [5:0] e;
    s[0] = HAZ_RS; s[1] = IDLE; s[2] = IDLE; s[3] = IDLE;
    s[1].rst = 1'b1;
    ev[0] = STALL; ev[1] = RSTV; ev[2] = NORM; ev[3] = NORM;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      drive(s[i]);
      exp_q.push_back(ev[i]);
      #1;
      e = exp_q.pop_front(); checks++;
      if (obs4 !== e) begin errors++; $display("FAIL reset_mid_stall cyc%0d: got %b expected %b", i, obs4, e); end
`ifdef HAZARD_PERF_CNT_EN
      if (i == 2) begin
        checks++;
        if (scnt4 !== 32'd0 || fcnt4 !== 32'd0) begin
          errors++; $display("FAIL reset_mid_stall_cnt: got %0d/%0d expected 0/0", scnt4, fcnt4);
        end
      end
`endif
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    idle(1);
    test_load_use_3();
    test_load_use_1();
    test_back_to_back();
    test_redirect();
    test_no_hazard();
    test_rs_eq_rt();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller. Drives the stall, bubble and flush inputs of the IF/ID and ID/EX pipeline registers, and the PC write enable.
- Detects load-use data hazards between the ID and EX stages and inserts one or more bubbles.
- Detects taken branches and jumps resolved in EX and flushes the two younger instructions.
- Sits beside the IF and ID stages and produces the bubble and flush signals that the ID/EX register consumes.

Parameters:
- LOAD_STALL_CYCLES, 1, number of bubbles inserted per load-use hazard. Legal range is 1..15; this covers data memories slower than one cycle.

Ports:
- Clk  input  1  clock. All state updates on negedge Clk, the same edge as the pipeline registers.
- Rst  input  1  synchronous active-high reset, sampled on negedge Clk.
- ID_Rs  input  5  rs field of the instruction in ID.
- ID_Rt  input  5  rt field of the instruction in ID.
- ID_UseRs  input  1  ID instruction reads rs.
- ID_UseRt  input  1  ID instruction reads rt, as a source operand or as store data.
- EX_Rw  input  5  destination register of the instruction in EX, after RegDst selection.
- EX_RegWr  input  1  EX instruction writes the register file.
- EX_MemtoReg  input  1  EX instruction is a load.
- EX_BrTaken  input  1  branch in EX is taken (Branch & Zero).
- EX_Jump  input  1  jump in EX.
- PC_Wr  output  1  PC register write enable.
- IF_ID_Wr  output  1  IF/ID register write enable.
- IF_ID_flush  output  1  IF/ID register loads a NOP.
- ID_EX_bubble  output  1  ID/EX register inserts a bubble.
- ID_EX_flush  output  1  ID/EX register squashes its input.
- stall_active  output  1  high in every cycle where the front end is held.

Behaviour:
- State register: st in {RUN, LD_STALL}, plus a 4-bit down-counter cnt.
- Reset: Rst=1 at negedge gives st=RUN, cnt=0.
- Outputs while Rst=1: PC_Wr=0, IF_ID_Wr=0, IF_ID_flush=1, ID_EX_flush=1, ID_EX_bubble=0, stall_active=0.
- Outputs are combinational from st, cnt and the current inputs (Mealy). There is no added latency: a hazard seen in a cycle is acted on at the next negedge.
- Hazard term: load_use = EX_MemtoReg & EX_RegWr & (EX_Rw != 0) & ((ID_UseRs & ID_Rs == EX_Rw) | (ID_UseRt & ID_Rt == EX_Rw)).
- Redirect term: redirect = EX_BrTaken | EX_Jump.
- RUN, priority 1 (redirect):
  - Outputs: PC_Wr=1, IF_ID_Wr=1, IF_ID_flush=1, ID_EX_flush=1, ID_EX_bubble=0, stall_active=0.
  - Next state stays RUN.
  - Redirect beats load_use, because the ID instruction is squashed anyway.
- RUN, priority 2 (load_use):
  - Outputs: PC_Wr=0, IF_ID_Wr=0, ID_EX_bubble=1, both flushes 0, stall_active=1.
  - If LOAD_STALL_CYCLES > 1: next st=LD_STALL, cnt=LOAD_STALL_CYCLES-1.
  - Otherwise: stay in RUN.
- RUN, otherwise:
  - Outputs: PC_Wr=1, IF_ID_Wr=1, all flush and bubble outputs 0, stall_active=0.
- LD_STALL:
  - Outputs: PC_Wr=0, IF_ID_Wr=0, ID_EX_bubble=1, both flushes 0, stall_active=1.
  - Each negedge, cnt decrements. When cnt==1, next st=RUN and cnt=0.
  - load_use and redirect are ignored in this state. EX only holds bubbles here, so redirect=1 in LD_STALL is a protocol error; the bench asserts on it.
- Register 0: EX_Rw==0 never causes a stall.
- Rs==Rt: when both fields match EX_Rw, exactly one stall sequence is taken, not two.
- Rst mid-stall: st returns to RUN and cnt to 0 at that negedge. Reset outputs apply while Rst=1.
- Exclusivity: ID_EX_bubble and ID_EX_flush are never both 1.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds two output ports, stall_cnt[31:0] and flush_cnt[31:0]. Both reset to 0 on Rst.
  - stall_cnt increments at each negedge where ID_EX_bubble=1.
  - flush_cnt increments at each negedge where ID_EX_flush=1 and Rst=0.
  - Both counters wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load then use, LOAD_STALL_CYCLES=1: EX lw with EX_Rw=8, ID add with ID_Rs=8 and ID_UseRs=1 -> one cycle with PC_Wr=0, IF_ID_Wr=0, ID_EX_bubble=1. Next cycle (EX now bubble) all outputs normal.
- LOAD_STALL_CYCLES=3, same hazard -> exactly 3 consecutive cycles with stall_active=1, then RUN. stall_cnt advances by 3 with HAZARD_PERF_CNT_EN.
- EX_BrTaken=1 together with load_use=1 (EX_Rw=8, ID_Rt=8) -> IF_ID_flush=1, ID_EX_flush=1, PC_Wr=1, ID_EX_bubble=0. No stall follows.
- Load to register 0: EX_Rw=0, ID_Rs=0 -> no stall; PC_Wr=1.
- ID_UseRt=0 with ID_Rt==EX_Rw=9 (lw in EX) -> no stall.
- LOAD_STALL_CYCLES=4, Rst=1 asserted in the 2nd stall cycle -> reset outputs while Rst=1. After release, st=RUN with no residual stall, and the counters are 0 with HAZARD_PERF_CNT_EN.
